// File: rtl/round_arbiter.sv
// Round control for the tug-of-war game: ready light with random delay, first-push detection, one pulse per round.
// Optional LIGHT_TIMEOUT_EN: abandon a lit round after TIMEOUT cycles with a tied (no-score) pulse.
module round_arbiter #(
    parameter int          DELAY_W   = 4,
    parameter int          MIN_DELAY = 16,
    parameter int          HOLD_CYC  = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pb_l,
    input  logic       pb_r,
    input  logic [7:0] score,
    output logic       leds_on,
    output logic       winrnd,
    output logic       right,
    output logic       tie,
    output logic       game_over
);

    localparam int DCNT_W = $clog2(MIN_DELAY + (1 << DELAY_W) + 1);
    localparam int HCNT_W = $clog2(HOLD_CYC + 1);
    localparam logic [7:0] WIN_L = 8'b11100000;
    localparam logic [7:0] WIN_R = 8'b00000111;

    typedef enum logic [2:0] {
        WAIT_REL = 3'd0,
        DARK     = 3'd1,
        LIGHT    = 3'd2,
        SCORE    = 3'd3,
        HOLD     = 3'd4,
        GAMEOVER = 3'd5
    } state_t;

    state_t              state, state_d;
    logic [2:0]          sync_l, sync_r;
    logic                push_l, push_r;
    logic [15:0]         lfsr;
    logic [DCNT_W-1:0]   dcnt;
    logic [HCNT_W-1:0]   hcnt;
    logic                lat_l, lat_r, jump;
    logic                timeout;

`ifdef LIGHT_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    logic [TCNT_W-1:0]   tcnt;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    // Bit 0 and 1 are the synchronizer, bit 2 the edge-detect delay flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_l <= '0;
            sync_r <= '0;
            lfsr   <= LFSR_SEED;
        end else begin
            sync_l <= {sync_l[1:0], pb_l};
            sync_r <= {sync_r[1:0], pb_r};
            lfsr   <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign push_l = sync_l[1] & ~sync_l[2];
    assign push_r = sync_r[1] & ~sync_r[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_REL;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        timeout = 1'b0;
        case (state)
            WAIT_REL: if (!sync_l[1] && !sync_r[1]) state_d = DARK;
            // A push on the cycle the delay expires still counts as a jump.
            DARK: begin
                if (push_l || push_r)         state_d = SCORE;
                else if (dcnt <= DCNT_W'(1))  state_d = LIGHT;
            end
            LIGHT: begin
                if (push_l || push_r) begin
                    state_d = SCORE;
                end
`ifdef LIGHT_TIMEOUT_EN
                else if (tcnt <= TCNT_W'(1)) begin
                    state_d = SCORE;
                    timeout = 1'b1;
                end
`endif
            end
            SCORE: state_d = HOLD;
            HOLD: begin
                if (hcnt == '0) state_d = (score == WIN_L || score == WIN_R) ? GAMEOVER : WAIT_REL;
            end
            GAMEOVER: state_d = GAMEOVER;
            default:  state_d = WAIT_REL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt  <= '0;
            hcnt  <= '0;
            lat_l <= 1'b0;
            lat_r <= 1'b0;
            jump  <= 1'b0;
`ifdef LIGHT_TIMEOUT_EN
            tcnt  <= '0;
`endif
        end else begin
            case (state)
                WAIT_REL: dcnt <= DCNT_W'(MIN_DELAY) + DCNT_W'(lfsr[DELAY_W-1:0]);
                DARK: begin
                    dcnt <= dcnt - DCNT_W'(1);
`ifdef LIGHT_TIMEOUT_EN
                    tcnt <= TCNT_W'(TIMEOUT);
`endif
                end
`ifdef LIGHT_TIMEOUT_EN
                LIGHT: tcnt <= tcnt - TCNT_W'(1);
`endif
                SCORE: hcnt <= HCNT_W'(HOLD_CYC - 1);
                HOLD:  if (hcnt != '0) hcnt <= hcnt - HCNT_W'(1);
                default: ;
            endcase
            // A timed-out round is reported as a tie so the scorer leaves the score alone.
            if (state_d == SCORE) begin
                lat_l <= push_l | timeout;
                lat_r <= push_r | timeout;
                jump  <= (state == DARK);
            end
        end
    end

    always_comb begin
        leds_on   = 1'b0;
        winrnd    = 1'b0;
        right     = 1'b0;
        tie       = 1'b0;
        game_over = 1'b0;
        case (state)
            LIGHT: leds_on = 1'b1;
            SCORE: begin
                winrnd  = 1'b1;
                right   = lat_r & ~lat_l;
                tie     = lat_l & lat_r;
                leds_on = ~jump;
            end
            GAMEOVER: game_over = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_round_arbiter.sv
// Directed bench for round_arbiter: light delay, round pulses, jump, tie, game over and light timeout.
module tb_round_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       pb_l, pb_r;
    logic [7:0] score;
    logic       leds_on, winrnd, right, tie, game_over;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    round_arbiter #(
        .DELAY_W  (2),
        .MIN_DELAY(4),
        .HOLD_CYC (4),
        .LFSR_SEED(16'hACE1),
        .TIMEOUT  (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pb_l     (pb_l),
        .pb_r     (pb_r),
        .score    (score),
        .leds_on  (leds_on),
        .winrnd   (winrnd),
        .right    (right),
        .tie      (tie),
        .game_over(game_over)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_leds"},   32'(leds_on),   0);
        check({tag, "_winrnd"}, 32'(winrnd),    0);
        check({tag, "_right"},  32'(right),     0);
        check({tag, "_tie"},    32'(tie),       0);
        check({tag, "_gover"},  32'(game_over), 0);
    endtask

    initial begin
        int   n;
        logic seen;

        rst = 1'b1; pb_l = 1'b0; pb_r = 1'b0; score = 8'h00;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;

        // Seed low bits 01 -> delay 5; edge 1 leaves WAIT_REL, light after edge 6.
        n = 0; seen = 1'b0;
        while (!leds_on && n < 20) begin
            tick(); n++;
            if (winrnd) seen = 1'b1;
        end
        check("first_light_delay", n, 6);
        check("first_dark_no_win", 32'(seen), 0);
        repeat (2) begin
            tick();
            check("light_steady", 32'(leds_on), 1);
            check("light_no_win", 32'(winrnd), 0);
        end

        // Right push in LIGHT: pulse after edge k+2.
        pb_r = 1'b1;
        tick(); check("r_edge_k",  32'(winrnd), 0);
        tick(); check("r_edge_k1", 32'(winrnd), 0);
        tick();
        check("r_win",   32'(winrnd),  1);
        check("r_right", 32'(right),   1);
        check("r_tie",   32'(tie),     0);
        check("r_leds",  32'(leds_on), 1);
        tick();
        check("r_pulse_one_cycle", 32'(winrnd), 0);
        check("r_hold_leds", 32'(leds_on), 0);
        pb_r = 1'b0;

        // HOLD ends at k+7, DARK from k+8 for at least 4 cycles; jump acted on at k+10.
        repeat (4) begin
            tick();
            check("pre_jump_leds", 32'(leds_on), 0);
            check("pre_jump_win",  32'(winrnd),  0);
        end
        pb_l = 1'b1;
        tick(); check("j_dark_leds", 32'(leds_on), 0);
        tick(); check("j_no_win_yet", 32'(winrnd), 0);
        tick();
        check("j_win",   32'(winrnd),  1);
        check("j_leds",  32'(leds_on), 0);
        check("j_right", 32'(right),   0);
        check("j_tie",   32'(tie),     0);
        tick();
        check("j_pulse_one_cycle", 32'(winrnd), 0);
        pb_l = 1'b0;

        // Tie round in LIGHT.
        n = 0; seen = 1'b0;
        while (!leds_on && n < 40) begin
            tick(); n++;
            if (winrnd) seen = 1'b1;
        end
        check("tie_light_seen", 32'(leds_on), 1);
        check("tie_wait_no_win", 32'(seen), 0);
        pb_l = 1'b1; pb_r = 1'b1;
        tick(); check("t_edge_k",  32'(winrnd), 0);
        tick(); check("t_edge_k1", 32'(winrnd), 0);
        tick();
        check("t_win",   32'(winrnd),  1);
        check("t_tie",   32'(tie),     1);
        check("t_right", 32'(right),   0);
        check("t_leds",  32'(leds_on), 1);
        pb_l = 1'b0; pb_r = 1'b0;
        score = 8'b00000111;

        // HOLD of 4 cycles, then GAMEOVER.
        repeat (4) begin
            tick();
            check("hold_no_gover", 32'(game_over), 0);
            check("hold_no_win",   32'(winrnd),    0);
        end
        tick();
        check("gover_set",  32'(game_over), 1);
        check("gover_leds", 32'(leds_on),   0);

        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            pb_r = (i >= 5 && i < 12);
            pb_l = (i >= 15 && i < 25);
            tick();
            if (winrnd || leds_on) seen = 1'b1;
        end
        check("gover_no_round", 32'(seen), 0);
        check("gover_sticky",   32'(game_over), 1);

        // Reset leaves GAMEOVER and restarts the LFSR.
        pb_l = 1'b0; pb_r = 1'b0;
        rst = 1'b1;
        tick();
        check_idle_outputs("rerst");
        score = 8'h00;
        rst = 1'b0;
        n = 0;
        while (!leds_on && n < 20) begin
            tick(); n++;
        end
        check("second_light_delay", n, 6);

`ifdef LIGHT_TIMEOUT_EN
        n = 0;
        while (!winrnd && n < 40) begin
            tick(); n++;
        end
        check("to_delay", n, 10);
        check("to_tie",   32'(tie),     1);
        check("to_right", 32'(right),   0);
        check("to_leds",  32'(leds_on), 1);
        tick();
        check("to_pulse_one_cycle", 32'(winrnd), 0);
`else
        seen = 1'b0;
        repeat (1000) begin
            tick();
            if (winrnd) seen = 1'b1;
        end
        check("no_to_no_win", 32'(seen), 0);
        check("no_to_leds",   32'(leds_on), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
